// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by both the transmitter and the receiver.
//   state_t      : transmitter/receiver frame state (IDLE / TRANSMITTING)
//   BAUD_DIV_DEF : default clk cycles per bit (100 MHz / 38400)
//   PAR_*        : parity mode encodings
//   frame_bits() : number of bits in one frame for a given parity mode
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic {
        IDLE         = 1'b0,
        TRANSMITTING = 1'b1
    } state_t;

    localparam int BAUD_DIV_DEF = 2604;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // start + 8 data + [parity] + stop
    function automatic int frame_bits(input int parity);
        return (parity == PAR_NONE) ? 10 : 11;
    endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl_if
// Host-side handshake of the UART transmitter.
//   trmt     : host -> tx, one-cycle pulse starting a frame
//   tx_data  : host -> tx, byte to send (sampled on accepted trmt)
//   clr_done : host -> tx, clears tx_done
//   TX       : tx -> line, serial output, idle high
//   busy     : tx -> host, frame in progress
//   tx_done  : tx -> host, sticky frame-complete flag
// master = host side, slave = transmitter side.
// ---------------------------------------------------------------------------
interface uart_tx_ctrl_if;

    logic       trmt;
    logic [7:0] tx_data;
    logic       clr_done;
    logic       TX;
    logic       busy;
    logic       tx_done;

    modport master (
        output trmt, tx_data, clr_done,
        input  TX, busy, tx_done
    );

    modport slave (
        input  trmt, tx_data, clr_done,
        output TX, busy, tx_done
    );

endinterface

// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
// UART transmitter, LSB first, start/8 data/[parity]/stop framing.
// Parameters:
//   BAUD_DIV : clk cycles per bit, 16..4095
//   PARITY   : PAR_NONE / PAR_EVEN / PAR_ODD
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : uart_tx_ctrl_if.slave (trmt, tx_data, clr_done in;
//           TX, busy, tx_done out)
// ---------------------------------------------------------------------------
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEF,
    parameter int PARITY   = PAR_NONE
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_tx_ctrl_if.slave  bus
);

    localparam logic [3:0]  LAST_BIT  = 4'(frame_bits(PARITY) - 1);
    localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);

    state_t      state_q,    state_d;
    logic [10:0] shft_q,     shft_d;
    logic [11:0] baud_cnt_q, baud_cnt_d;
    logic [3:0]  bit_cnt_q,  bit_cnt_d;
    logic        tx_q,       tx_d;
    logic        busy_q,     busy_d;
    logic        done_q,     done_d;

    logic        shift;
    logic        par_bit;

    assign shift   = (baud_cnt_q == BAUD_LAST);
    assign par_bit = (PARITY == PAR_ODD) ? ~^bus.tx_data : ^bus.tx_data;

    // NOTE: every signal gets its hold value first so no path leaves it
    // unassigned; that is what keeps this block free of latches.
    always_comb begin
        state_d    = state_q;
        shft_d     = shft_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        busy_d     = busy_q;
        done_d     = done_q;

        if (bus.clr_done) begin
            done_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                baud_cnt_d = '0;
                if (bus.trmt) begin
                    // Unused top bit for the no-parity frame is just extra stop level.
                    shft_d    = (PARITY == PAR_NONE) ? {2'b11, bus.tx_data, 1'b0}
                                                     : {1'b1, par_bit, bus.tx_data, 1'b0};
                    bit_cnt_d = '0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    state_d   = TRANSMITTING;
                end
            end
            TRANSMITTING: begin
                if (shift) begin
                    baud_cnt_d = '0;
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                    // Shift in ones so the line rests high once the stop bit ends.
                    shft_d     = {1'b1, shft_q[10:1]};
                    if (bit_cnt_q == LAST_BIT) begin
                        busy_d  = 1'b0;
                        done_d  = ~bus.clr_done;
                        state_d = IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 12'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // TX follows the next shift-register LSB so the start bit appears on the
    // same edge that accepts trmt.
    assign tx_d = shft_d[0];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shft_q     <= '1;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shft_q     <= shft_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.TX      = tx_q;
    assign bus.busy    = busy_q;
    assign bus.tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_ctrl
// Drives three fast transmitters (BAUD_DIV=16; no/even/odd parity) from one
// shared stimulus and one full-rate transmitter (BAUD_DIV=2604, no parity)
// from its own trmt. Expected line waveforms come from frame words: either
// hand-written constants or a popcount-based model of the frame format.
// ---------------------------------------------------------------------------
module tb_uart_tx_ctrl;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       trmt;
    logic       trmt_s;
    logic [7:0] tx_data;
    logic       clr_done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx_ctrl_if if0 ();
    uart_tx_ctrl_if if1 ();
    uart_tx_ctrl_if if2 ();
    uart_tx_ctrl_if ifs ();

    assign if0.trmt = trmt;   assign if0.tx_data = tx_data; assign if0.clr_done = clr_done;
    assign if1.trmt = trmt;   assign if1.tx_data = tx_data; assign if1.clr_done = clr_done;
    assign if2.trmt = trmt;   assign if2.tx_data = tx_data; assign if2.clr_done = clr_done;
    assign ifs.trmt = trmt_s; assign ifs.tx_data = tx_data; assign ifs.clr_done = clr_done;

    uart_tx_ctrl #(.BAUD_DIV(16),   .PARITY(PAR_NONE)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    uart_tx_ctrl #(.BAUD_DIV(16),   .PARITY(PAR_EVEN)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    uart_tx_ctrl #(.BAUD_DIV(16),   .PARITY(PAR_ODD))  u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
    uart_tx_ctrl #(.BAUD_DIV(2604), .PARITY(PAR_NONE)) u_duts (.clk(clk), .rst_n(rst_n), .bus(ifs.slave));

    typedef struct {
        logic [7:0]  data;
        logic [10:0] w_none;  // {stop-level, stop, data, start} bit 0 sent first
        logic [10:0] w_even;  // {stop, parity, data, start}
        logic [10:0] w_odd;
    } vec_t;

    vec_t vecs[5];

    // {TX, busy, tx_done} of DUT d
    function automatic logic [2:0] outs(input int d);
        case (d)
            0:       return {if0.TX, if0.busy, if0.tx_done};
            1:       return {if1.TX, if1.busy, if1.tx_done};
            2:       return {if2.TX, if2.busy, if2.tx_done};
            default: return {ifs.TX, ifs.busy, ifs.tx_done};
        endcase
    endfunction

    function automatic int nbits_of(input int d);
        return (d == 1 || d == 2) ? 11 : 10;
    endfunction

    function automatic int baud_of(input int d);
        return (d == 3) ? 2604 : 16;
    endfunction

    // Reference frame word: parity from counting ones in the byte.
    function automatic logic [10:0] model_word(input logic [7:0] data, input int par);
        int   ones = 0;
        logic p;
        for (int i = 0; i < 8; i++) ones += int'(data[i]);
        if (par == PAR_NONE) return {2'b11, data, 1'b0};
        p = (par == PAR_EVEN) ? logic'(ones % 2) : logic'(1 - ones % 2);
        return {1'b1, p, data, 1'b0};
    endfunction

    task automatic check(input string what, input int d, input int k,
                         input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s dut%0d cycle %0d: got %b expected %b", what, d, k, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_reset(input int d, input int k);
        logic [2:0] o;
        o = outs(d);
        check("rst_TX",   d, k, o[2], 1'b1);
        check("rst_busy", d, k, o[1], 1'b0);
        check("rst_done", d, k, o[0], 1'b0);
    endtask

    // Launch one frame and compare every cycle from the trmt edge to
    // max frame length + extra against the frame words.
    //   inject_k : cycle at which a stray trmt with 8'h3C is pulsed (-1 none)
    //   with_clr : assert clr_done together with the launching trmt
    //   reset_k  : cycle at which rst_n is pulsed low and the task ends (-1 none)
    task automatic run_frames(input logic slow, input logic [7:0] data,
                              input logic [10:0] w0, input logic [10:0] w1,
                              input logic [10:0] w2, input int inject_k,
                              input logic with_clr, input int reset_k,
                              input int extra);
        logic [10:0] word[4];
        int          len[4];
        int          first, last, maxlen;
        logic [2:0]  o;
        logic        e_tx;

        word[0] = w0; word[1] = w1; word[2] = w2; word[3] = w0;
        first   = slow ? 3 : 0;
        last    = slow ? 3 : 2;
        maxlen  = 0;
        for (int d = first; d <= last; d++) begin
            len[d] = nbits_of(d) * baud_of(d);
            if (len[d] > maxlen) maxlen = len[d];
        end

        tx_data  = data;
        clr_done = with_clr;
        if (slow) trmt_s = 1'b1; else trmt = 1'b1;
        tick();
        trmt     = 1'b0;
        trmt_s   = 1'b0;
        clr_done = 1'b0;

        for (int k = 0; k <= maxlen + extra; k++) begin
            if (k == 3) tx_data = ~data;
            if (k == inject_k) begin
                tx_data = 8'h3C;
                trmt    = 1'b1;
            end else begin
                trmt    = 1'b0;
            end
            if (k == reset_k) begin
                rst_n = 1'b0;
                #2;
                for (int d = 0; d < 4; d++) check_idle_reset(d, k);
                #1 rst_n = 1'b1;
                trmt = 1'b0;
                return;
            end
            for (int d = first; d <= last; d++) begin
                o    = outs(d);
                e_tx = (k < len[d]) ? word[d][k / baud_of(d)] : 1'b1;
                check("TX",      d, k, o[2], e_tx);
                check("busy",    d, k, o[1], k < len[d]);
                check("tx_done", d, k, o[0], k >= len[d]);
            end
            tick();
        end
        trmt = 1'b0;
    endtask

    initial begin
        logic [7:0] rd;

        vecs[0] = '{8'hA5, 11'b11101001010, 11'b10101001010, 11'b11101001010};
        vecs[1] = '{8'h07, 11'b11000001110, 11'b11000001110, 11'b10000001110};
        vecs[2] = '{8'hFF, 11'b11111111110, 11'b10111111110, 11'b11111111110};
        vecs[3] = '{8'h55, 11'b11010101010, 11'b10010101010, 11'b11010101010};
        vecs[4] = '{8'h00, 11'b11000000000, 11'b10000000000, 11'b11000000000};

        rst_n    = 1'b1;
        trmt     = 1'b0;
        trmt_s   = 1'b0;
        tx_data  = 8'h00;
        clr_done = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) tick();
        for (int d = 0; d < 4; d++) check_idle_reset(d, -1);
        rst_n = 1'b1;
        tick();

        // Full-rate frame
        run_frames(1'b1, vecs[0].data, vecs[0].w_none, vecs[0].w_none, vecs[0].w_none,
                   -1, 1'b0, -1, 3);

        // Table-driven frames on the three parity variants
        for (int i = 0; i < 5; i++)
            run_frames(1'b0, vecs[i].data, vecs[i].w_none, vecs[i].w_even, vecs[i].w_odd,
                       -1, 1'b0, -1, 2);

        // Stray trmt mid-frame: ignored, no second frame afterwards
        run_frames(1'b0, vecs[2].data, vecs[2].w_none, vecs[2].w_even, vecs[2].w_odd,
                   80, 1'b0, -1, 40);

        // Back-to-back: trmt on the cycle after tx_done rises on the 11-bit frames
        run_frames(1'b0, vecs[1].data, vecs[1].w_none, vecs[1].w_even, vecs[1].w_odd,
                   -1, 1'b0, -1, 0);
        run_frames(1'b0, vecs[0].data, vecs[0].w_none, vecs[0].w_even, vecs[0].w_odd,
                   -1, 1'b0, -1, 2);

        // clr_done alone, then clr_done together with trmt
        clr_done = 1'b1;
        tick();
        clr_done = 1'b0;
        for (int d = 0; d < 3; d++) check("clr_done", d, 0, outs(d)[0], 1'b0);
        run_frames(1'b0, vecs[3].data, vecs[3].w_none, vecs[3].w_even, vecs[3].w_odd,
                   -1, 1'b0, -1, 1);
        run_frames(1'b0, 8'h3C, model_word(8'h3C, PAR_NONE), model_word(8'h3C, PAR_EVEN),
                   model_word(8'h3C, PAR_ODD), -1, 1'b1, -1, 2);

        // Asynchronous reset in the middle of data bit 3 (bit index 4), then a clean frame
        run_frames(1'b0, vecs[0].data, vecs[0].w_none, vecs[0].w_even, vecs[0].w_odd,
                   4 * 16 + 8, 1'b0, 4 * 16 + 8, 0);
        tick();
        run_frames(1'b0, vecs[3].data, vecs[3].w_none, vecs[3].w_even, vecs[3].w_odd,
                   -1, 1'b0, -1, 2);

        // Random bytes against the model
        for (int i = 0; i < 8; i++) begin
            rd = 8'($urandom_range(0, 255));
            run_frames(1'b0, rd, model_word(rd, PAR_NONE), model_word(rd, PAR_EVEN),
                       model_word(rd, PAR_ODD), -1, 1'b0, -1, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
